// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage issue control for the 5-stage MIPS pipeline.
//               Keeps a pending-write counter per architectural register.
//               Stalls decode on RAW hazards or when the in-flight write
//               budget is exhausted. Holds flush for a fixed number of
//               cycles after an accepted j/jr.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [4:0] issue_rs,
    input  logic [4:0] issue_rt,
    input  logic       issue_uses_rt,
    input  logic       issue_wr_en,
    input  logic [4:0] issue_rd,
    input  logic       issue_jmp,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    output logic       stall,
    output logic       flush,
    output logic [3:0] inflight,
    output logic       err_underflow
);

    localparam logic [CNT_W-1:0] C_PEND_MAX     = '1;
    localparam logic [3:0]       C_MAX_INFLIGHT = 4'(MAX_INFLIGHT);
    localparam logic [2:0]       C_FLUSH_LOAD   = 3'(FLUSH_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_pend [32];
    logic [3:0]       r_inflight;
    logic             r_err;

    logic w_idle;
    logic w_rs_busy;
    logic w_rt_busy;
    logic w_rd_nz;
    logic w_rd_full;
    logic w_stall;
    logic w_accept;
    logic w_inc;
    logic w_wb_nz;
    logic w_dec;
    logic w_underflow;
    logic w_flush;

    // Entry 0 is never written, so reads of $0 always see zero pending.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_rs_busy   = (r_pend[issue_rs] != '0);
    assign w_rt_busy   = (r_pend[issue_rt] != '0);
    assign w_rd_nz     = (issue_rd != 5'd0);
    assign w_rd_full   = (r_inflight == C_MAX_INFLIGHT) || (r_pend[issue_rd] == C_PEND_MAX);
    assign w_stall     = issue_valid && w_idle &&
                         (w_rs_busy || (issue_uses_rt && w_rt_busy) ||
                          (issue_wr_en && w_rd_nz && w_rd_full));
    assign w_accept    = issue_valid && w_idle && !w_stall;
    assign w_inc       = w_accept && issue_wr_en && w_rd_nz;
    assign w_wb_nz     = wb_valid && (wb_rd != 5'd0);
    assign w_dec       = w_wb_nz && (r_pend[wb_rd] != '0);
    assign w_underflow = w_wb_nz && (r_pend[wb_rd] == '0);

    // Per-register pending counters; same-register inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if ((w_inc && (issue_rd == 5'(i))) && !(w_dec && (wb_rd == 5'(i)))) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if ((w_dec && (wb_rd == 5'(i))) && !(w_inc && (issue_rd == 5'(i)))) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
        end
    end

    // Total outstanding writes, kept equal to the sum of all counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 4'd0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

    // Flush window length counter, loaded when a jump is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= 3'd0;
        end else if (w_accept && issue_jmp) begin
            r_flush_cnt <= C_FLUSH_LOAD;
        end else if (!w_idle && (r_flush_cnt != 3'd0)) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and flush output.
    always_comb begin
        w_state_next = r_state;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && issue_jmp) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (r_flush_cnt <= 3'd1) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign inflight      = r_inflight;
    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard
//               (MAX_INFLIGHT=4, CNT_W=2, FLUSH_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rs;
    logic [4:0] issue_rt;
    logic       issue_uses_rt;
    logic       issue_wr_en;
    logic [4:0] issue_rd;
    logic       issue_jmp;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       stall;
    logic       flush;
    logic [3:0] inflight;
    logic       err_underflow;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .MAX_INFLIGHT(4),
        .CNT_W       (2),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_uses_rt(issue_uses_rt),
        .issue_wr_en  (issue_wr_en),
        .issue_rd     (issue_rd),
        .issue_jmp    (issue_jmp),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall        (stall),
        .flush        (flush),
        .inflight     (inflight),
        .err_underflow(err_underflow)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled shortly after.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic wr, input logic [4:0] rd,
                               input logic jmp);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rt      = rt;
        issue_uses_rt = urt;
        issue_wr_en   = wr;
        issue_rd      = rd;
        issue_jmp     = jmp;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_rd    = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        drive_wb(0, 0);
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (stall !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL idle_after_reset stall=%b flush=%b exp=0/0", stall, flush); end
    endtask

    task automatic test_raw();
        drive_issue(1, 0, 0, 0, 1, 5, 0);          // addi $5
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_accept stall=%b exp=0", stall); end
        tick();
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL raw_inflight1 got=%0d exp=1", inflight); end
        drive_issue(1, 5, 0, 1, 1, 8, 0);          // add $8,$5,$0
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%b exp=1", stall); end
        tick();
        drive_wb(1, 5);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass got=%b exp=1", stall); end
        tick();
        drive_wb(0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release got=%b exp=0", stall); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL raw_inflight0 got=%0d exp=0", inflight); end
        tick();                                    // add accepted, $8 pending
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL raw_add_counted got=%0d exp=1", inflight); end
        drive_issue(1, 0, 8, 0, 0, 0, 0);          // rt=$8 not read
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rt_unused_nostall got=%b exp=0", stall); end
        drive_issue(1, 0, 8, 1, 0, 0, 0);          // rt=$8 read
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rt_used_stall got=%b exp=1", stall); end
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        drive_wb(1, 8);
        tick();
        drive_wb(0, 0);
        #1;
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL raw_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_capacity();
        for (int i = 1; i <= 4; i++) begin
            drive_issue(1, 0, 0, 0, 1, 5'(i), 0);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cap_fill_%0d stall=%b exp=0", i, stall); end
            tick();
        end
        checks++; if (inflight !== 4'd4) begin errors++; $display("FAIL cap_full got=%0d exp=4", inflight); end
        drive_issue(1, 0, 0, 0, 1, 6, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cap_stall got=%b exp=1", stall); end
        drive_wb(1, 1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cap_wb_same_cycle got=%b exp=1", stall); end
        tick();
        drive_wb(0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cap_release got=%b exp=0", stall); end
        checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL cap_after_wb got=%0d exp=3", inflight); end
        tick();
        checks++; if (inflight !== 4'd4) begin errors++; $display("FAIL cap_fifth_accepted got=%0d exp=4", inflight); end
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive_wb(1, (i == 3) ? 5'd6 : 5'(i + 2));
            tick();
        end
        drive_wb(0, 0);
        #1;
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL cap_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            drive_issue(1, 0, 0, 0, 1, 10, 0);
            tick();
        end
        checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL sat_inflight got=%0d exp=3", inflight); end
        drive_issue(1, 0, 0, 0, 1, 10, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got=%b exp=1", stall); end
        drive_issue(1, 0, 0, 0, 1, 0, 0);          // rd=$0 never stalls on capacity
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_rd0_nostall got=%b exp=0", stall); end
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_wb(1, 10);
            tick();
        end
        drive_wb(0, 0);
        #1;
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL sat_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_jump_flush();
        drive_issue(1, 0, 0, 0, 0, 0, 1);          // j
        #1;
        checks++; if (stall !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL jmp_c0 stall=%b flush=%b exp=0/0", stall, flush); end
        tick();
        drive_issue(1, 0, 0, 0, 1, 11, 0);         // wrong-path write, must be ignored
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp_c1_flush got=%b exp=1", flush); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jmp_c1_stall got=%b exp=0", stall); end
        tick();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp_c2_flush got=%b exp=1", flush); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL jmp_c2_inflight got=%0d exp=0", inflight); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jmp_c3_flush got=%b exp=0", flush); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL jmp_c3_inflight got=%0d exp=0", inflight); end
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_simultaneous();
        drive_issue(1, 0, 0, 0, 1, 7, 0);
        tick();
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL sim_setup got=%0d exp=1", inflight); end
        drive_issue(1, 0, 0, 0, 1, 7, 0);
        drive_wb(1, 7);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sim_waw_nostall got=%b exp=0", stall); end
        tick();
        drive_wb(0, 0);
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL sim_inflight got=%0d exp=1", inflight); end
        drive_issue(1, 7, 0, 0, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sim_pend7_still1 got=%b exp=1", stall); end
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        drive_wb(1, 7);
        tick();
        drive_wb(1, 0);                            // wb to $0 ignored entirely
        drive_issue(1, 0, 0, 0, 1, 0, 0);          // write to $0 never counted
        tick();
        drive_wb(0, 0);
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL sim_rd0_uncounted got=%0d exp=0", inflight); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sim_wb0_noerr got=%b exp=0", err_underflow); end
    endtask

    task automatic test_underflow_reset();
        drive_wb(1, 9);
        tick();
        drive_wb(0, 0);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL uf_inflight got=%0d exp=0", inflight); end
        tick();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
        drive_issue(1, 0, 0, 0, 1, 31, 1);         // jr that also writes $31
        tick();
        drive_issue(1, 31, 0, 0, 0, 0, 0);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rst_pre_flush got=%b exp=1", flush); end
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL rst_jmp_counted got=%0d exp=1", inflight); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_async_flush got=%b exp=0", flush); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_async_err got=%b exp=0", err_underflow); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL rst_async_inflight got=%0d exp=0", inflight); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 1'b0;
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        drive_wb(1, 31);                           // stale pre-reset writeback
        tick();
        drive_wb(0, 0);
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL rst_stale_wb got=%b exp=1", err_underflow); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_capacity();
        test_saturation();
        test_jump_flush();
        test_simultaneous();
        test_underflow_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Issue-control block for the decode stage of the 5-stage MIPS pipeline. Tracks outstanding register writes per architectural register and stalls decode on RAW hazards or in-flight overflow. Generates a timed flush window after taken jumps (j/jr) so wrong-path fetches are squashed. Sits beside instr_decode, driving its freeze and flush controls, and observes writeback.

Parameters:
MAX_INFLIGHT, 4, maximum accepted-but-not-written-back register writes (1..15)
CNT_W, 2, width of each per-register pending counter (saturates at 2^CNT_W-1)
FLUSH_CYCLES, 1, cycles flush is held after an accepted jump (1..7)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
issue_valid  in  1  decode holds a valid instruction this cycle
issue_rs  in  5  source register 1 (instr[25:21])
issue_rt  in  5  source register 2 (instr[20:16])
issue_uses_rt  in  1  rt is read as an operand (R-type, beq/bne, sw)
issue_wr_en  in  1  instruction writes a register
issue_rd  in  5  destination register (reg_dest)
issue_jmp  in  1  instruction is j/jr (decode jFlag)
wb_valid  in  1  writeback commits a register write this cycle
wb_rd  in  5  writeback destination register
stall  out  1  hold decode and fetch; instruction not accepted
flush  out  1  squash fetch/decode contents
inflight  out  4  current count of outstanding writes
err_underflow  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (async, rst=1): all pending counters 0, inflight=0, FSM=IDLE, flush counter 0, err_underflow=0; stall=0 and flush=0 while in reset.
- Register $0: never marked pending; issue_rd=0 or wb_rd=0 ignored for counting; rs/rt=0 never hazard.
- stall (combinational from registered state and current issue inputs) = issue_valid & state==IDLE & (pend[rs]!=0 | (issue_uses_rt & pend[rt]!=0) | (issue_wr_en & rd!=0 & (inflight==MAX_INFLIGHT | pend[rd]==2^CNT_W-1))).
- No writeback bypass: a wb in the same cycle does not clear the stall; the hazard releases the following cycle (1-cycle stall minimum after wb).
- accept = issue_valid & !stall & state==IDLE.
- On accept with issue_wr_en & rd!=0: pend[rd]+1, inflight+1 at next edge.
- On wb_valid & wb_rd!=0: pend[wb_rd]-1, inflight-1. If pend[wb_rd]==0: no change, err_underflow set (sticky until reset), inflight unchanged.
- Same-cycle accept and wb to same register: net counter change 0; inflight net 0.
- FSM IDLE: on accept & issue_jmp -> FLUSH, load flush counter with FLUSH_CYCLES. The jump itself is accepted (and counted if it writes).
- FSM FLUSH: flush=1; stall=0; issue_valid ignored (no accept, no counter change); counter decrements each cycle; when counter reaches 1 -> IDLE next edge. flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the jump is accepted.
- Writebacks are processed in every state, including FLUSH.
- Reset asserted mid-FLUSH or with writes outstanding: all state cleared immediately; later writebacks of pre-reset instructions raise err_underflow (expected; pipeline is also reset).
- inflight is registered; equals sum of all pend[] at all times.

Test Plan:
- Reset then idle: rst pulse, issue_valid=0 -> stall=0, flush=0, inflight=0, err_underflow=0.
- RAW stall: accept addi rd=5; next cycle issue add rs=5 -> stall=1; wb_valid rd=5 at cycle 3 -> stall still 1 at cycle 3, 0 at cycle 4; inflight 1->0.
- Capacity: accept 4 writes to rd=1,2,3,4 with no wb -> inflight=4; 5th write rd=6 -> stall=1; wb rd=1 -> 5th accepted next cycle, inflight=4.
- Jump flush with FLUSH_CYCLES=2: accept j at cycle 0 -> flush=1 cycles 1-2, issue_valid ignored there (inflight unchanged), IDLE at cycle 3.
- Simultaneous: pend[7]=1, accept write rd=7 and wb rd=7 same cycle -> pend[7]=1, inflight unchanged; rd=0 writes never stall or count.
- Underflow and mid-op reset: wb rd=9 with pend[9]=0 -> err_underflow=1 sticky; assert rst during FLUSH -> flush=0 and err_underflow=0 immediately (asynchronously).
